sand_tile_sequencer: RTL and testbench

- Initiator side of the sand grid tile RAM interface: sweeps every tile of the active buffer and reads it.
- Hands each tile to an external toppling compute unit over a valid/ready handshake.
- Writes the result to the same address in the inactive buffer, then flips the ping-pong select at the end of each sweep.
- Also performs grid clear, and counts generations until the grid is stable.

---
 rtl/sand_tile_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_sand_tile_sequencer.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sand_tile_sequencer.sv
// Tile sweep sequencer for a ping-pong sand grid RAM: reads every tile of the active
// buffer, hands it to a toppling compute unit, writes the result to the other buffer.
module sand_tile_sequencer #(
  parameter int ROWS        = 128,
  parameter int COLS        = 128,
  parameter int ROWS_TILE   = 4,
  parameter int COLS_TILE   = 4,
  parameter int CELL_WIDTH  = 3,
  parameter int TILE_SIZE   = ROWS_TILE * COLS_TILE,
  parameter int TILES_TOTAL = ROWS * COLS / TILE_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             clear,
  input  logic                             run,
  output logic [9:0]                       tile_addr,
  output logic                             read_tile,
  output logic                             write_tile,
  output logic                             reset_tile,
  output logic                             read_ram_a,
  input  logic [CELL_WIDTH*TILE_SIZE-1:0]  tile_rdata,
  output logic [CELL_WIDTH*TILE_SIZE-1:0]  tile_wdata,
  output logic                             cmp_valid,
  input  logic                             cmp_ready,
  output logic [9:0]                       cmp_addr,
  output logic [CELL_WIDTH*TILE_SIZE-1:0]  cmp_tile,
  input  logic                             res_valid,
  input  logic [CELL_WIDTH*TILE_SIZE-1:0]  res_tile,
  input  logic                             res_changed,
  output logic                             busy,
  output logic                             stable,
  output logic                             done,
  output logic [15:0]                      gen_count
);

  localparam int         TILE_W    = CELL_WIDTH * TILE_SIZE;
  localparam logic [9:0] LAST_ADDR = 10'(TILES_TOTAL - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR0,
    S_CLR1,
    S_RD,
    S_RDC,
    S_CMP,
    S_WRES,
    S_WR,
    S_NEXT,
    S_SWAP
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [9:0]          addr;
  logic [TILE_W-1:0]   tile_q;
  logic [TILE_W-1:0]   res_q;
  logic                sweep_changed;

  // Control strobes from the next-state logic to the datapath registers
  logic addr_zero;
  logic addr_inc;
  logic sel_toggle;
  logic tile_load;
  logic res_load;
  logic changed_clr;
  logic sweep_end;
  logic clear_end;
  logic done_next;

  logic last_addr;
  assign last_addr = (addr == LAST_ADDR);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    read_tile   = 1'b0;
    write_tile  = 1'b0;
    reset_tile  = 1'b0;
    cmp_valid   = 1'b0;
    addr_zero   = 1'b0;
    addr_inc    = 1'b0;
    sel_toggle  = 1'b0;
    tile_load   = 1'b0;
    res_load    = 1'b0;
    changed_clr = 1'b0;
    sweep_end   = 1'b0;
    clear_end   = 1'b0;
    done_next   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next  = S_RD;
          addr_zero   = 1'b1;
          changed_clr = 1'b1;
        end else if (clear) begin
          state_next = S_CLR0;
          addr_zero  = 1'b1;
        end
      end

      S_CLR0: begin
        reset_tile = 1'b1;
        if (last_addr) begin
          sel_toggle = 1'b1;
          addr_zero  = 1'b1;
          state_next = S_CLR1;
        end else begin
          addr_inc = 1'b1;
        end
      end

      S_CLR1: begin
        reset_tile = 1'b1;
        if (last_addr) begin
          sel_toggle = 1'b1;
          addr_zero  = 1'b1;
          clear_end  = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          addr_inc = 1'b1;
        end
      end

      S_RD: begin
        read_tile  = 1'b1;
        state_next = S_RDC;
      end

      // The RAM read mux is gated by read_tile, so the strobe is held while capturing.
      S_RDC: begin
        read_tile  = 1'b1;
        tile_load  = 1'b1;
        state_next = S_CMP;
      end

      S_CMP: begin
        cmp_valid = 1'b1;
        if (cmp_ready) state_next = S_WRES;
      end

      S_WRES: begin
        if (res_valid) begin
          res_load   = 1'b1;
          state_next = S_WR;
        end
      end

      S_WR: begin
        write_tile = 1'b1;
        state_next = S_NEXT;
      end

      S_NEXT: begin
        if (last_addr) begin
          state_next = S_SWAP;
        end else begin
          addr_inc   = 1'b1;
          state_next = S_RD;
        end
      end

      S_SWAP: begin
        sel_toggle = 1'b1;
        sweep_end  = 1'b1;
        addr_zero  = 1'b1;
        if (run && sweep_changed) begin
          changed_clr = 1'b1;
          state_next  = S_RD;
        end else begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      read_ram_a    <= 1'b1;
      stable        <= 1'b0;
      gen_count     <= '0;
      sweep_changed <= 1'b0;
      done          <= 1'b0;
      // NOTE: the tile registers are small and drive outputs, so they are reset too;
      // a real RAM array would not be.
      tile_q        <= '0;
      res_q         <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;

      if (addr_zero)     addr <= '0;
      else if (addr_inc) addr <= addr + 10'd1;

      if (sel_toggle) read_ram_a <= ~read_ram_a;
      if (tile_load)  tile_q     <= tile_rdata;
      if (res_load)   res_q      <= res_tile;

      if (changed_clr)                  sweep_changed <= 1'b0;
      else if (res_load && res_changed) sweep_changed <= 1'b1;

      if (clear_end) begin
        gen_count <= '0;
        stable    <= 1'b0;
      end else if (sweep_end) begin
        if (gen_count != 16'hFFFF) gen_count <= gen_count + 16'd1;
        stable <= ~sweep_changed;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign tile_addr  = addr;
  assign cmp_addr   = addr;
  assign cmp_tile   = tile_q;
  assign tile_wdata = res_q;

endmodule

// File: tb/tb_sand_tile_sequencer.sv
// Bench for sand_tile_sequencer: ping-pong tile RAM model, compute-unit responder and a
// buffer-level reference model of clear and sweep behaviour.
module tb_sand_tile_sequencer;

  localparam int CW    = 3;
  localparam int TS    = 16;
  localparam int TW    = CW * TS;
  localparam int TILES = 1024;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          run   = 1'b0;
  logic [9:0]    tile_addr;
  logic          read_tile, write_tile, reset_tile, read_ram_a;
  logic [TW-1:0] tile_rdata, tile_wdata, cmp_tile;
  logic          cmp_valid;
  logic          cmp_ready   = 1'b0;
  logic [9:0]    cmp_addr;
  logic          res_valid   = 1'b0;
  logic [TW-1:0] res_tile    = '0;
  logic          res_changed = 1'b0;
  logic          busy, stable, done;
  logic [15:0]   gen_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sand_tile_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .run         (run),
    .tile_addr   (tile_addr),
    .read_tile   (read_tile),
    .write_tile  (write_tile),
    .reset_tile  (reset_tile),
    .read_ram_a  (read_ram_a),
    .tile_rdata  (tile_rdata),
    .tile_wdata  (tile_wdata),
    .cmp_valid   (cmp_valid),
    .cmp_ready   (cmp_ready),
    .cmp_addr    (cmp_addr),
    .cmp_tile    (cmp_tile),
    .res_valid   (res_valid),
    .res_tile    (res_tile),
    .res_changed (res_changed),
    .busy        (busy),
    .stable      (stable),
    .done        (done),
    .gen_count   (gen_count)
  );

  // Tile RAM: one-cycle registered read, output gated by read_tile; writes/zeroes go to
  // the buffer not being read.
  logic [TW-1:0] mem_a  [TILES];
  logic [TW-1:0] mem_b  [TILES];
  logic [TW-1:0] fill_a [TILES];
  logic [TW-1:0] fill_b [TILES];
  logic [TW-1:0] rdata_q  = '0;
  logic          fill_req = 1'b0;

  always @(posedge clk) begin
    if (fill_req)
      for (int i = 0; i < TILES; i++) begin
        mem_a[i] <= fill_a[i];
        mem_b[i] <= fill_b[i];
      end
    if (read_tile) rdata_q <= read_ram_a ? mem_a[tile_addr] : mem_b[tile_addr];
    if (write_tile || reset_tile) begin
      if (read_ram_a) mem_b[tile_addr] <= write_tile ? tile_wdata : '0;
      else            mem_a[tile_addr] <= write_tile ? tile_wdata : '0;
    end
  end

  assign tile_rdata = read_tile ? rdata_q : '0;

  // Compute-unit responder configuration (written by the stimulus only)
  bit            cu_xor       = 1'b0;
  logic [TW-1:0] cu_key       = '0;
  bit            cu_rand      = 1'b0;
  bit            cu_bp_en     = 1'b0;
  logic [9:0]    cu_bp_addr   = 10'd7;
  int            cu_bp_len    = 5;
  bit            cu_hold_en   = 1'b0;
  logic [9:0]    cu_hold_addr = 10'd300;
  int            cu_base      = 0;
  int            cu_chg_limit = 0;

  bit            pend = 1'b0;
  logic [TW-1:0] p_tile = '0;
  logic [9:0]    p_addr = '0;
  bit            p_chg = 1'b0;
  int            res_wait = 0;
  int            stall_left = 0;
  bit            in_cmp = 1'b0;
  int            hs_cnt = 0;

  always @(negedge clk) begin
    res_valid = 1'b0;
    cmp_ready = 1'b0;
    if (pend) begin
      if (res_wait == 0) begin
        res_valid   = 1'b1;
        res_tile    = cu_xor ? (p_tile ^ cu_key) : p_tile;
        res_changed = p_chg;
        pend        = 1'b0;
      end else begin
        res_wait--;
      end
    end else if (cmp_valid === 1'b1) begin
      if (!in_cmp) begin
        in_cmp     = 1'b1;
        stall_left = (cu_bp_en && cmp_addr == cu_bp_addr) ? cu_bp_len
                   : (cu_rand ? int'($urandom_range(0, 1)) : 0);
      end
      if (stall_left == 0) begin
        cmp_ready = 1'b1;
        in_cmp    = 1'b0;
        pend      = 1'b1;
        p_tile    = cmp_tile;
        p_addr    = cmp_addr;
        p_chg     = (hs_cnt - cu_base) < cu_chg_limit;
        hs_cnt++;
        res_wait  = (cu_hold_en && cmp_addr == cu_hold_addr) ? 20
                  : (cu_rand ? int'($urandom_range(0, 1)) : 0);
      end else begin
        stall_left--;
      end
    end
  end

  // Bus monitor
  typedef struct {
    logic [9:0]    addr;
    logic [TW-1:0] data;
    logic          sel;
  } wr_t;

  typedef struct {
    logic [9:0] addr;
    logic       sel;
  } clr_t;

  bit            log_clr = 1'b0;
  int            cyc = 0;
  int            excl_err = 0;
  int            cmp_unstable = 0;
  int            done_cnt = 0;
  bit            rd_prev = 1'b0;
  bit            cv_prev = 1'b0;
  logic [9:0]    cv_addr_prev = '0;
  logic [TW-1:0] cv_tile_prev = '0;
  int            cv_run = 0;
  int            cv_len [TILES];
  int            rd_addr_q [$];
  int            rd_cyc_q  [$];
  wr_t           wr_q      [$];
  int            wr_cyc_q  [$];
  clr_t          clr_q     [$];

  always @(negedge clk) begin
    cyc++;
    if (log_clr) begin
      rd_addr_q.delete();
      rd_cyc_q.delete();
      wr_q.delete();
      wr_cyc_q.delete();
      clr_q.delete();
      done_cnt     = 0;
      cmp_unstable = 0;
      for (int i = 0; i < TILES; i++) cv_len[i] = 0;
    end
    if ((int'(read_tile) + int'(write_tile) + int'(reset_tile)) > 1) excl_err++;
    if (read_tile && !rd_prev) begin
      rd_addr_q.push_back(int'(tile_addr));
      rd_cyc_q.push_back(cyc);
    end
    rd_prev = read_tile;
    if (write_tile) begin
      wr_q.push_back('{addr: tile_addr, data: tile_wdata, sel: read_ram_a});
      wr_cyc_q.push_back(cyc);
    end
    if (reset_tile) clr_q.push_back('{addr: tile_addr, sel: read_ram_a});
    if (done) done_cnt++;
    if (cmp_valid) begin
      if (cv_prev && (cmp_addr !== cv_addr_prev || cmp_tile !== cv_tile_prev)) cmp_unstable++;
      cv_run = cv_prev ? cv_run + 1 : 1;
    end else if (cv_prev) begin
      cv_len[cv_addr_prev] = cv_run;
    end
    cv_prev      = cmp_valid;
    cv_addr_prev = cmp_addr;
    cv_tile_prev = cmp_tile;
  end

  // Reference model: whole-buffer view of the grid
  logic [TW-1:0] m_a  [TILES];
  logic [TW-1:0] m_b  [TILES];
  logic [TW-1:0] snap [TILES];
  bit            m_sel = 1'b1;
  int            m_gen = 0;
  bit            m_stable = 1'b0;

  task automatic model_clear();
    for (int i = 0; i < TILES; i++) begin
      m_a[i] = '0;
      m_b[i] = '0;
    end
    m_gen    = 0;
    m_stable = 1'b0;
  endtask

  // One full sweep: the inactive buffer receives f(active), then the buffers swap roles.
  task automatic model_sweep(input bit use_key, input logic [TW-1:0] key, input bit changed);
    for (int i = 0; i < TILES; i++) begin
      if (m_sel) m_b[i] = use_key ? (m_a[i] ^ key) : m_a[i];
      else       m_a[i] = use_key ? (m_b[i] ^ key) : m_b[i];
    end
    m_sel    = !m_sel;
    m_gen    = (m_gen < 65535) ? m_gen + 1 : m_gen;
    m_stable = !changed;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 64'(n >= budget), 64'(0));
    tick();
  endtask

  function automatic logic [TW-1:0] rnd_tile();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[TW-1:0];
  endfunction

  task automatic preload();
    for (int i = 0; i < TILES; i++) begin
      fill_a[i] = rnd_tile();
      fill_b[i] = rnd_tile();
      m_a[i]    = fill_a[i];
      m_b[i]    = fill_b[i];
    end
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  task automatic compare_state(input string tag);
    int bad_a = 0;
    int bad_b = 0;
    for (int i = 0; i < TILES; i++) begin
      if (mem_a[i] !== m_a[i]) bad_a++;
      if (mem_b[i] !== m_b[i]) bad_b++;
    end
    check({tag, "_buf_a_bad_tiles"}, 64'(bad_a), 64'(0));
    check({tag, "_buf_b_bad_tiles"}, 64'(bad_b), 64'(0));
    check({tag, "_read_ram_a"}, 64'(read_ram_a), 64'(m_sel));
    check({tag, "_gen_count"}, 64'(gen_count), 64'(m_gen));
    check({tag, "_stable"}, 64'(stable), 64'(m_stable));
  endtask

  initial begin
    int bad;
    int n;
    bit s0;
    int k;
    bit chg;

    // Reset state
    cycles(3);
    check("reset_strobes", 64'({read_tile, write_tile, reset_tile, cmp_valid, done, busy}), 64'(0));
    check("reset_tile_addr", 64'(tile_addr), 64'(0));
    check("reset_read_ram_a", 64'(read_ram_a), 64'(1));
    check("reset_stable_gen", 64'({stable, gen_count}), 64'(0));
    check("reset_data_regs", 64'(tile_wdata | cmp_tile), 64'(0));
    rst = 1'b0;
    tick();

    // Clear: both buffers zeroed, one tile per cycle, read_ram_a 1 then 0 then back to 1
    preload();
    clear_logs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_done(2200, "clear");
    check("clear_reset_cycles", 64'(clr_q.size()), 64'(2 * TILES));
    bad = 0;
    foreach (clr_q[j])
      if (int'(clr_q[j].addr) != (j % TILES) || clr_q[j].sel != (j < TILES)) bad++;
    check("clear_addr_sel_order", 64'(bad), 64'(0));
    check("clear_no_rd_wr", 64'(rd_addr_q.size() + wr_q.size()), 64'(0));
    check("clear_done_pulses", 64'(done_cnt), 64'(1));
    model_clear();
    compare_state("clear");

    // Single echo sweep with immediate ready/result
    preload();
    clear_logs();
    cu_xor = 1'b0; cu_rand = 1'b0; cu_chg_limit = 0;
    run = 1'b0;
    for (int i = 0; i < TILES; i++) snap[i] = m_sel ? m_a[i] : m_b[i];
    s0 = m_sel;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(7000, "echo");
    check("echo_read_count", 64'(rd_addr_q.size()), 64'(TILES));
    check("echo_write_count", 64'(wr_q.size()), 64'(TILES));
    bad = 0;
    foreach (rd_addr_q[j]) if (rd_addr_q[j] != j) bad++;
    check("echo_read_order", 64'(bad), 64'(0));
    bad = 0;
    foreach (wr_q[j])
      if (int'(wr_q[j].addr) != j || wr_q[j].data !== snap[j] || wr_q[j].sel != s0) bad++;
    check("echo_write_addr_data", 64'(bad), 64'(0));
    bad = 0;
    for (int j = 1; j < rd_cyc_q.size(); j++) if (rd_cyc_q[j] - rd_cyc_q[j-1] != 6) bad++;
    check("echo_six_cycles_per_tile", 64'(bad), 64'(0));
    check("echo_done_pulses", 64'(done_cnt), 64'(1));
    model_sweep(1'b0, '0, 1'b0);
    compare_state("echo");

    // Run mode: random key, random handshake delays, changes reported in sweeps 1-2
    clear_logs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_done(2200, "clear2");
    model_clear();
    preload();
    clear_logs();
    cu_xor = 1'b1; cu_key = rnd_tile() | 48'd1; cu_rand = 1'b1;
    cu_base = hs_cnt; cu_chg_limit = 2 * TILES;
    s0 = m_sel;
    run = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(32000, "run");
    run = 1'b0;
    k = 0;
    do begin
      k++;
      chg = (k <= 2);
      model_sweep(1'b1, cu_key, chg);
    end while (chg);
    check("run_write_count", 64'(wr_q.size()), 64'(k * TILES));
    check("run_read_count", 64'(rd_addr_q.size()), 64'(k * TILES));
    bad = 0;
    foreach (wr_q[j])
      if (int'(wr_q[j].addr) != (j % TILES) || wr_q[j].sel != (s0 ^ ((j / TILES) % 2 == 1))) bad++;
    check("run_write_addr_sel", 64'(bad), 64'(0));
    check("run_done_pulses", 64'(done_cnt), 64'(1));
    compare_state("run");

    // Backpressure: cmp_ready held low for 5 cycles on tile 7
    clear_logs();
    cu_xor = 1'b0; cu_rand = 1'b0; cu_chg_limit = 0;
    cu_bp_en = 1'b1; cu_bp_addr = 10'd7; cu_bp_len = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(7000, "bp");
    cu_bp_en = 1'b0;
    check("bp_valid_len_tile7", 64'(cv_len[7]), 64'(6));
    check("bp_valid_len_tile6", 64'(cv_len[6]), 64'(1));
    check("bp_cmp_stable_while_valid", 64'(cmp_unstable), 64'(0));
    check("bp_next_tile_is_8", 64'(rd_addr_q.size() > 8 ? rd_addr_q[8] : -1), 64'(8));
    check("bp_tile7_write_delay", 64'(wr_cyc_q.size() > 8 ? wr_cyc_q[7] - rd_cyc_q[7] : -1), 64'(9));
    check("bp_tile8_read_delay", 64'(rd_cyc_q.size() > 8 ? rd_cyc_q[8] - rd_cyc_q[7] : -1), 64'(11));
    check("bp_write_count", 64'(wr_q.size()), 64'(TILES));
    model_sweep(1'b0, '0, 1'b0);
    compare_state("bp");

    // Reset while waiting for the result of tile 300
    clear_logs();
    cu_hold_en = 1'b1; cu_hold_addr = 10'd300;
    s0 = m_sel;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(pend && p_addr == 10'd300) && n < 4000) begin
      tick();
      n++;
    end
    check("rst_reach_tile300_timeout", 64'(n >= 4000), 64'(0));
    tick();
    check("rst_pre_in_wres", 64'({busy, cmp_valid, read_tile, write_tile}), 64'(4'b1000));
    check("rst_pre_write_count", 64'(wr_q.size()), 64'(300));
    rst = 1'b1;
    tick();
    check("rst_abort_strobes", 64'({read_tile, write_tile, reset_tile, cmp_valid, done, busy}), 64'(0));
    check("rst_abort_addr", 64'(tile_addr), 64'(0));
    check("rst_abort_sel_gen", 64'({read_ram_a, gen_count}), 64'({1'b1, 16'd0}));
    rst = 1'b0;
    cycles(30);
    cu_hold_en = 1'b0;
    check("rst_stray_result_delivered", 64'(pend), 64'(0));
    check("rst_stray_result_ignored", 64'({busy, write_tile}), 64'(0));
    check("rst_no_write_after_abort", 64'(wr_q.size()), 64'(300));
    check("rst_no_done", 64'(done_cnt), 64'(0));
    for (int i = 0; i < 300; i++) begin
      if (s0) m_b[i] = m_a[i];
      else    m_a[i] = m_b[i];
    end
    m_sel = 1'b1; m_gen = 0; m_stable = 1'b0;
    compare_state("rst");

    // start and clear together: sweep wins; start/clear during the sweep are ignored
    clear_logs();
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("both_starts_sweep", 64'({read_tile, reset_tile}), 64'(2'b10));
    cycles(40);
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles(20);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_done(7000, "both");
    cycles(10);
    check("both_no_clear_seen", 64'(clr_q.size()), 64'(0));
    check("both_single_sweep_reads", 64'(rd_addr_q.size()), 64'(TILES));
    check("both_done_once", 64'(done_cnt), 64'(1));
    check("both_idle_after", 64'(busy), 64'(0));
    model_sweep(1'b0, '0, 1'b0);
    compare_state("both");

    check("strobe_exclusive", 64'(excl_err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
